// File: rtl/floo_vc_input_buffer_pkg.sv
// Shared helpers for the per-VC input buffer and its credit-return logic.
package floo_vc_input_buffer_pkg;

    // Index width that stays at least one bit wide for a single-entry set.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/floo_vc_credit_return.sv
// Tracks freed-but-unreturned credits per VC and returns at most one credit per
// cycle, round-robin among VCs whose pending count is non-zero after this cycle's pops.
module floo_vc_credit_return #(
    parameter int unsigned NumVC        = 5,
    parameter int unsigned VCIdxWidth   = 3,
    parameter int unsigned VCDepthWidth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumVC-1:0]      pop_i,
    output logic                  credit_valid_o,
    output logic [VCIdxWidth-1:0] credit_id_o
);

    logic [VCDepthWidth-1:0] pend_q [NumVC];
    logic [VCDepthWidth-1:0] pend_d [NumVC];
    logic [NumVC-1:0]        req;
    logic [NumVC-1:0]        gnt_oh;
    logic [VCIdxWidth-1:0]   cand [NumVC];
    logic [VCIdxWidth-1:0]   rr_q, rr_d;
    logic [VCIdxWidth-1:0]   gnt_idx;
    logic                    gnt_found;
    logic                    credit_valid_q;
    logic [VCIdxWidth-1:0]   credit_id_q;

    for (genvar gi = 0; gi < NumVC; gi++) begin : g_vc
        logic [VCIdxWidth:0] sum;

        // cand[gi] is the VC examined at priority position gi, starting at rr_q.
        assign sum      = {1'b0, rr_q} + (VCIdxWidth+1)'(gi);
        assign cand[gi] = (sum >= (VCIdxWidth+1)'(NumVC)) ?
                          VCIdxWidth'(sum - (VCIdxWidth+1)'(NumVC)) : sum[VCIdxWidth-1:0];

        // A pop in this cycle already counts as a pending credit.
        assign req[gi]    = (pend_q[gi] != '0) | pop_i[gi];
        assign gnt_oh[gi] = gnt_found & (gnt_idx == VCIdxWidth'(gi));
        assign pend_d[gi] = pend_q[gi] + VCDepthWidth'(pop_i[gi]) - VCDepthWidth'(gnt_oh[gi]);
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int off = 0; off < NumVC; off++) begin
            if (!gnt_found && req[cand[off]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[off];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_found) begin
            rr_d = (gnt_idx == VCIdxWidth'(NumVC - 1)) ? '0 : gnt_idx + VCIdxWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q           <= '0;
            credit_valid_q <= 1'b0;
            credit_id_q    <= '0;
            for (int v = 0; v < NumVC; v++) begin
                pend_q[v] <= '0;
            end
        end else begin
            rr_q           <= rr_d;
            credit_valid_q <= gnt_found;
            credit_id_q    <= gnt_found ? gnt_idx : '0;
            pend_q         <= pend_d;
        end
    end

    assign credit_valid_o = credit_valid_q;
    assign credit_id_o    = credit_id_q;

endmodule

// File: rtl/floo_vc_input_buffer.sv
// Receiver side of a per-VC credit link: one FIFO per virtual channel, no
// fall-through, one credit returned upstream for every flit popped.
module floo_vc_input_buffer
    import floo_vc_input_buffer_pkg::*;
#(
    parameter int unsigned NumVC         = 5,
    parameter int unsigned VCIdxWidthMax = 0,
    parameter int unsigned VCDepth       = 2,
    parameter int unsigned DeeperVCId    = 0,
    parameter int unsigned DeeperVCDepth = 2,
    parameter type         flit_t        = logic,
    parameter int unsigned VCIdxWidth    = idx_width(NumVC),
    parameter int unsigned VCDepthWidth  =
        $clog2(((DeeperVCDepth > VCDepth) ? DeeperVCDepth : VCDepth) + 1),
    // A link-wide id width of 0 means "just wide enough for this port".
    localparam int unsigned IdW = (VCIdxWidthMax == 0) ? VCIdxWidth : VCIdxWidthMax
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [IdW-1:0]   vc_id_i,
    input  flit_t            data_i,
    output logic [NumVC-1:0] vc_valid_o,
    output flit_t            vc_data_o [NumVC],
    input  logic [NumVC-1:0] vc_ready_i,
    output logic             credit_valid_o,
    output logic [IdW-1:0]   credit_id_o,
    output logic             overflow_o
);

    logic                  id_bad;
    logic [NumVC-1:0]      hit;
    logic [NumVC-1:0]      pop;
    logic [NumVC-1:0]      drop;
    logic                  overflow_q;
    logic [VCIdxWidth-1:0] credit_id;

    assign id_bad = (32'(vc_id_i) >= NumVC);

    for (genvar gi = 0; gi < NumVC; gi++) begin : g_vc
        localparam int unsigned Depth = (gi == DeeperVCId) ? DeeperVCDepth : VCDepth;
        localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
        localparam int unsigned CntW  = $clog2(Depth + 1);

        flit_t           mem_q [Depth];
        logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
        logic [CntW-1:0] cnt_q;
        logic            full;
        logic            push;

        assign hit[gi]  = valid_i & ~id_bad & (vc_id_i[VCIdxWidth-1:0] == VCIdxWidth'(gi));
        assign full     = (cnt_q == CntW'(Depth));
        assign pop[gi]  = (cnt_q != '0) & vc_ready_i[gi];
        // A full VC still accepts the write when its head leaves in the same cycle.
        assign push     = hit[gi] & (~full | pop[gi]);
        assign drop[gi] = hit[gi] & full & ~pop[gi];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
                end
                if (push && !pop[gi]) begin
                    cnt_q <= cnt_q + CntW'(1);
                end else if (pop[gi] && !push) begin
                    cnt_q <= cnt_q - CntW'(1);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end

        assign vc_valid_o[gi] = (cnt_q != '0);
        assign vc_data_o[gi]  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= (valid_i & id_bad) | (|drop);
        end
    end

    assign overflow_o = overflow_q;

    floo_vc_credit_return #(
        .NumVC        (NumVC),
        .VCIdxWidth   (VCIdxWidth),
        .VCDepthWidth (VCDepthWidth)
    ) u_credit (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pop_i          (pop),
        .credit_valid_o (credit_valid_o),
        .credit_id_o    (credit_id)
    );

    assign credit_id_o = IdW'(credit_id);

endmodule

// File: tb/tb_floo_vc_input_buffer.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_floo_vc_input_buffer;

    localparam int NVC = 5;
    localparam int IDW = 3;
    typedef logic [7:0] flit_t;

    logic           clk_i  = 1'b0;
    logic           rst_ni = 1'b0;
    logic           valid_i = 1'b0;
    logic [IDW-1:0] vc_id_i = '0;
    flit_t          data_i  = '0;
    logic [NVC-1:0] vc_valid_o;
    flit_t          vc_data_o [NVC];
    logic [NVC-1:0] vc_ready_i = '0;
    logic           credit_valid_o;
    logic [IDW-1:0] credit_id_o;
    logic           overflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    floo_vc_input_buffer #(
        .NumVC         (NVC),
        .VCIdxWidthMax (IDW),
        .VCDepth       (2),
        .DeeperVCId    (1),
        .DeeperVCDepth (4),
        .flit_t        (flit_t)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .vc_id_i        (vc_id_i),
        .data_i         (data_i),
        .vc_valid_o     (vc_valid_o),
        .vc_data_o      (vc_data_o),
        .vc_ready_i     (vc_ready_i),
        .credit_valid_o (credit_valid_o),
        .credit_id_o    (credit_id_o),
        .overflow_o     (overflow_o)
    );

    typedef struct {
        logic     vld;
        int       id;
        int       dat;
        logic [4:0] rdy;
        logic [4:0] e_vv;
        int       e_hv;   // VC whose head data is checked, -1 for none
        int       e_hd;
        logic     e_ovf;
        logic     e_cv;
        int       e_cid;
    } vec_t;

    vec_t tbl [20];

    // Reference model state
    flit_t mq [NVC][$];
    int    depth [NVC] = '{2, 4, 2, 2, 2};
    int    pend [NVC];
    int    pops [NVC];
    int    dut_cred [NVC];
    int    rr;
    logic  e_cv, e_ovf;
    int    e_cid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        valid_i    = 1'b0;
        vc_id_i    = '0;
        data_i     = '0;
        vc_ready_i = '0;
        rst_ni     = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    task automatic write(input int id, input int dat);
        valid_i = 1'b1;
        vc_id_i = IDW'(id);
        data_i  = 8'(dat);
        step();
        valid_i = 1'b0;
    endtask

    task automatic model_cycle();
        logic [NVC-1:0] popv;
        logic           drop;
        int             id;
        // compare DUT against the model state for this cycle
        for (int v = 0; v < NVC; v++) begin
            chk($sformatf("rand_valid_vc%0d", v), vc_valid_o[v], mq[v].size() != 0);
            if (mq[v].size() != 0) chk($sformatf("rand_head_vc%0d", v), vc_data_o[v], mq[v][0]);
            chk($sformatf("rand_pend_vc%0d", v), dut.u_credit.pend_q[v], pend[v]);
        end
        chk("rand_overflow", overflow_o, e_ovf);
        chk("rand_credit_valid", credit_valid_o, e_cv);
        if (e_cv) chk("rand_credit_id", credit_id_o, e_cid);
        if (credit_valid_o && credit_id_o < NVC) dut_cred[credit_id_o]++;
        // advance the model with the inputs driven in this cycle
        drop = 1'b0;
        id   = int'(vc_id_i);
        for (int v = 0; v < NVC; v++) popv[v] = vc_ready_i[v] && (mq[v].size() != 0);
        if (valid_i) begin
            if (id >= NVC) drop = 1'b1;
            else if (mq[id].size() == depth[id] && !popv[id]) drop = 1'b1;
        end
        for (int v = 0; v < NVC; v++) begin
            if (popv[v]) begin
                void'(mq[v].pop_front());
                pops[v]++;
                pend[v]++;
            end
        end
        if (valid_i && !drop) mq[id].push_back(data_i);
        e_ovf = drop;
        e_cv  = 1'b0;
        for (int k = 0; k < NVC; k++) begin
            int v;
            v = (rr + k) % NVC;
            if (!e_cv && pend[v] > 0) begin
                e_cv  = 1'b1;
                e_cid = v;
            end
        end
        if (e_cv) begin
            pend[e_cid]--;
            rr = (e_cid + 1) % NVC;
        end
        step();
    endtask

    initial begin
        int cnt1, cnt_all;

        // reset held
        #2;
        chk("rst_vc_valid", vc_valid_o, 0);
        chk("rst_credit_valid", credit_valid_o, 0);
        chk("rst_credit_id", credit_id_o, 0);
        chk("rst_overflow", overflow_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("idle_vc_valid", vc_valid_o, 0);
            chk("idle_credit_valid", credit_valid_o, 0);
            chk("idle_overflow", overflow_o, 0);
            step();
        end

        // directed vector table
        tbl[0]  = '{1'b1, 2, 'hA5, 5'b00000, 5'b00000, -1, 0,     1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 0, 0,    5'b00100, 5'b00100,  2, 'hA5,  1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 0, 0,    5'b00000, 5'b00000, -1, 0,     1'b0, 1'b1, 2};
        tbl[3]  = '{1'b1, 0, 'h11, 5'b00000, 5'b00000, -1, 0,     1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 0, 'h22, 5'b00000, 5'b00001,  0, 'h11,  1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1, 0, 'h33, 5'b00000, 5'b00001,  0, 'h11,  1'b0, 1'b0, 0};
        tbl[6]  = '{1'b0, 0, 0,    5'b00000, 5'b00001,  0, 'h11,  1'b1, 1'b0, 0};
        tbl[7]  = '{1'b0, 0, 0,    5'b00001, 5'b00001,  0, 'h11,  1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 0, 0,    5'b00001, 5'b00001,  0, 'h22,  1'b0, 1'b1, 0};
        tbl[9]  = '{1'b0, 0, 0,    5'b00001, 5'b00000, -1, 0,     1'b0, 1'b1, 0};
        tbl[10] = '{1'b0, 0, 0,    5'b00000, 5'b00000, -1, 0,     1'b0, 1'b0, 0};
        tbl[11] = '{1'b1, 6, 'h77, 5'b00000, 5'b00000, -1, 0,     1'b0, 1'b0, 0};
        tbl[12] = '{1'b0, 0, 0,    5'b00000, 5'b00000, -1, 0,     1'b1, 1'b0, 0};
        tbl[13] = '{1'b0, 0, 0,    5'b00000, 5'b00000, -1, 0,     1'b0, 1'b0, 0};
        tbl[14] = '{1'b1, 4, 'h44, 5'b00000, 5'b00000, -1, 0,     1'b0, 1'b0, 0};
        tbl[15] = '{1'b1, 4, 'h45, 5'b10000, 5'b10000,  4, 'h44,  1'b0, 1'b0, 0};
        tbl[16] = '{1'b0, 0, 0,    5'b00000, 5'b10000,  4, 'h45,  1'b0, 1'b1, 4};
        tbl[17] = '{1'b0, 0, 0,    5'b10000, 5'b10000,  4, 'h45,  1'b0, 1'b0, 0};
        tbl[18] = '{1'b0, 0, 0,    5'b00000, 5'b00000, -1, 0,     1'b0, 1'b1, 4};
        tbl[19] = '{1'b0, 0, 0,    5'b00000, 5'b00000, -1, 0,     1'b0, 1'b0, 0};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            valid_i    = tbl[i].vld;
            vc_id_i    = IDW'(tbl[i].id);
            data_i     = 8'(tbl[i].dat);
            vc_ready_i = tbl[i].rdy;
            chk($sformatf("tbl%0d_vc_valid", i), vc_valid_o, tbl[i].e_vv);
            if (tbl[i].e_hv >= 0) chk($sformatf("tbl%0d_head", i), vc_data_o[tbl[i].e_hv], tbl[i].e_hd);
            chk($sformatf("tbl%0d_overflow", i), overflow_o, tbl[i].e_ovf);
            chk($sformatf("tbl%0d_credit_valid", i), credit_valid_o, tbl[i].e_cv);
            if (tbl[i].e_cv) chk($sformatf("tbl%0d_credit_id", i), credit_id_o, tbl[i].e_cid);
            step();
        end
        valid_i    = 1'b0;
        vc_ready_i = '0;

        // credit contention: three pops in one cycle, credits serialised 0,1,3
        do_reset();
        write(0, 'h10);
        write(1, 'h11);
        write(3, 'h13);
        chk("cont_vc_valid", vc_valid_o, 5'b01011);
        vc_ready_i = 5'b01011;
        step();
        vc_ready_i = '0;
        chk("cont_cv_t1", credit_valid_o, 1);
        chk("cont_id_t1", credit_id_o, 0);
        step();
        chk("cont_cv_t2", credit_valid_o, 1);
        chk("cont_id_t2", credit_id_o, 1);
        step();
        chk("cont_cv_t3", credit_valid_o, 1);
        chk("cont_id_t3", credit_id_o, 3);
        step();
        chk("cont_cv_t4", credit_valid_o, 0);
        for (int v = 0; v < NVC; v++) chk($sformatf("cont_pend_vc%0d", v), dut.u_credit.pend_q[v], 0);
        chk("cont_vc_valid_end", vc_valid_o, 0);

        // deeper VC1: four writes fit, the fifth overflows
        do_reset();
        for (int k = 0; k < 4; k++) begin
            write(1, 'h20 + k);
            chk($sformatf("deep_no_ovf%0d", k), overflow_o, 0);
        end
        write(1, 'h99);
        chk("deep_ovf", overflow_o, 1);
        step();
        chk("deep_ovf_pulse", overflow_o, 0);
        cnt1 = 0;
        cnt_all = 0;
        for (int k = 0; k < 4; k++) begin
            vc_ready_i = 5'b00010;
            chk($sformatf("deep_valid%0d", k), vc_valid_o[1], 1);
            chk($sformatf("deep_head%0d", k), vc_data_o[1], 'h20 + k);
            if (credit_valid_o) cnt_all++;
            if (credit_valid_o && credit_id_o == 1) cnt1++;
            step();
        end
        vc_ready_i = '0;
        for (int k = 0; k < 3; k++) begin
            if (credit_valid_o) cnt_all++;
            if (credit_valid_o && credit_id_o == 1) cnt1++;
            step();
        end
        chk("deep_credits_id1", cnt1, 4);
        chk("deep_credits_total", cnt_all, 4);
        chk("deep_empty", vc_valid_o, 0);

        // full VC0 with write and pop in the same cycle
        do_reset();
        write(0, 'h01);
        write(0, 'h02);
        chk("fullpop_vc_valid", vc_valid_o, 5'b00001);
        valid_i    = 1'b1;
        vc_id_i    = 3'd0;
        data_i     = 8'h03;
        vc_ready_i = 5'b00001;
        chk("fullpop_head0", vc_data_o[0], 'h01);
        step();
        valid_i    = 1'b0;
        vc_ready_i = '0;
        chk("fullpop_no_ovf", overflow_o, 0);
        chk("fullpop_cv", credit_valid_o, 1);
        chk("fullpop_cid", credit_id_o, 0);
        chk("fullpop_head1", vc_data_o[0], 'h02);
        step();
        chk("fullpop_cv_once", credit_valid_o, 0);
        vc_ready_i = 5'b00001;
        step();
        chk("fullpop_valid2", vc_valid_o[0], 1);
        chk("fullpop_head2", vc_data_o[0], 'h03);
        step();
        vc_ready_i = '0;
        chk("fullpop_empty", vc_valid_o[0], 0);

        // randomized run against the queue model
        do_reset();
        for (int v = 0; v < NVC; v++) begin
            mq[v].delete();
            pend[v] = 0;
            pops[v] = 0;
            dut_cred[v] = 0;
        end
        rr    = 0;
        e_cv  = 1'b0;
        e_ovf = 1'b0;
        e_cid = 0;
        for (int c = 0; c < 2000; c++) begin
            valid_i = ($urandom_range(0, 9) < 6);
            vc_id_i = ($urandom_range(0, 15) == 0) ? IDW'($urandom_range(5, 7))
                                                   : IDW'($urandom_range(0, 4));
            data_i  = 8'($urandom);
            vc_ready_i = (c < 1000) ? (5'($urandom) & 5'($urandom)) : 5'($urandom);
            model_cycle();
        end
        valid_i    = 1'b0;
        vc_ready_i = '1;
        for (int c = 0; c < 40; c++) model_cycle();
        vc_ready_i = '0;
        for (int v = 0; v < NVC; v++) begin
            chk($sformatf("rand_credits_vc%0d", v), dut_cred[v], pops[v]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
